// File: rtl/pic16_idec_if.sv
// Handshake and ALU-control bundle between the PIC16 decode stage (slave)
// and the surrounding core / ALU (master).
interface pic16_idec_if;
  logic [13:0] ir;
  logic        ir_vld;
  logic        ir_rdy;
  logic [4:0]  cb;
  logic [2:0]  b;
  logic [7:0]  lit;
  logic        lsel;
  logic [6:0]  fadr;
  logic        fre;
  logic        we;
  logic        fwe;
  logic        ci;
  logic        co;
  logic        dc;
  logic        z;
  logic        c_f;
  logic        dc_f;
  logic        z_f;
  logic        stw;
  logic [2:0]  sdi;
  logic        br;

  modport slave (
    input  ir, ir_vld, co, dc, z, stw, sdi,
    output ir_rdy, cb, b, lit, lsel, fadr, fre, we, fwe, ci, c_f, dc_f, z_f, br
  );

  modport master (
    output ir, ir_vld, co, dc, z, stw, sdi,
    input  ir_rdy, cb, b, lit, lsel, fadr, fre, we, fwe, ci, c_f, dc_f, z_f, br
  );
endinterface

// File: rtl/pic16_idec.sv
// PIC16 instruction decode and Q1-Q4 sequencer: drives ALU control and write
// strobes, owns the STATUS C/DC/Z flags and the skip-next-instruction state.
module pic16_idec (
  input  logic        clk,
  input  logic        rst,
  pic16_idec_if.slave bus
);
  // ALU op codes, same values as alu_op.v
  localparam logic [4:0] IADD  = 5'd0;
  localparam logic [4:0] ISUB  = 5'd1;
  localparam logic [4:0] IAND  = 5'd2;
  localparam logic [4:0] IIOR  = 5'd3;
  localparam logic [4:0] IXOR  = 5'd4;
  localparam logic [4:0] ICLR  = 5'd5;
  localparam logic [4:0] INTF  = 5'd6;
  localparam logic [4:0] IDEC1 = 5'd7;
  localparam logic [4:0] IDEC2 = 5'd8;
  localparam logic [4:0] IINC1 = 5'd9;
  localparam logic [4:0] IINC2 = 5'd10;
  localparam logic [4:0] IPSF  = 5'd11;
  localparam logic [4:0] IPSW  = 5'd12;
  localparam logic [4:0] IRLF  = 5'd13;
  localparam logic [4:0] IRRF  = 5'd14;
  localparam logic [4:0] ISWP  = 5'd15;
  localparam logic [4:0] IBCF  = 5'd16;
  localparam logic [4:0] IBSF  = 5'd17;
  localparam logic [4:0] IBTF  = 5'd18;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_Q1   = 3'd1;
  localparam logic [2:0] S_Q2   = 3'd2;
  localparam logic [2:0] S_Q3   = 3'd3;
  localparam logic [2:0] S_Q4   = 3'd4;

  logic [2:0]  state;
  logic [13:0] ir_q;
  logic        skip_pend;
  logic        c_f, dc_f, z_f;

  logic [4:0]  op;
  logic        lit_op, br_op, wr_w, wr_f, rd_f;
  logic        upd_c, upd_dc, upd_z, sk_z, sk_nz;
  logic        accept, active, exec, in_q4, flag_upd, skip_set;

  always_comb begin
    op     = IPSW;
    lit_op = 1'b0;
    br_op  = 1'b0;
    wr_w   = 1'b0;
    wr_f   = 1'b0;
    rd_f   = 1'b0;
    upd_c  = 1'b0;
    upd_dc = 1'b0;
    upd_z  = 1'b0;
    sk_z   = 1'b0;
    sk_nz  = 1'b0;
    case (ir_q[13:12])
      2'b00: begin
        // Byte ops: d selects the file register (1) or W (0) as destination.
        rd_f  = 1'b1;
        upd_z = 1'b1;
        wr_f  = ir_q[7];
        wr_w  = ~ir_q[7];
        case (ir_q[11:8])
          4'b0111: begin op = IADD; upd_c = 1'b1; upd_dc = 1'b1; end
          4'b0010: begin op = ISUB; upd_c = 1'b1; upd_dc = 1'b1; end
          4'b0101: op = IAND;
          4'b0100: op = IIOR;
          4'b0110: op = IXOR;
          4'b0001: begin op = ICLR; rd_f = 1'b0; end
          4'b1001: op = INTF;
          4'b0011: op = IDEC1;
          4'b1010: op = IINC1;
          4'b1000: op = IPSF;
          4'b1011: begin op = IDEC2; upd_z = 1'b0; sk_z = 1'b1; end
          4'b1111: begin op = IINC2; upd_z = 1'b0; sk_z = 1'b1; end
          4'b1101: begin op = IRLF; upd_c = 1'b1; upd_z = 1'b0; end
          4'b1100: begin op = IRRF; upd_c = 1'b1; upd_z = 1'b0; end
          4'b1110: begin op = ISWP; upd_z = 1'b0; end
          // 0000: MOVWF when d=1, otherwise a NOP-class encoding.
          default: begin rd_f = 1'b0; upd_z = 1'b0; wr_w = 1'b0; end
        endcase
      end
      2'b01: begin
        rd_f = 1'b1;
        case (ir_q[11:10])
          2'b00:   begin op = IBCF; wr_f = 1'b1; end
          2'b01:   begin op = IBSF; wr_f = 1'b1; end
          2'b10:   begin op = IBTF; sk_z = 1'b1; end
          default: begin op = IBTF; sk_nz = 1'b1; end
        endcase
      end
      2'b10: br_op = 1'b1;
      default: begin
        casez (ir_q[11:8])
          4'b00??: begin op = IPSF; lit_op = 1'b1; wr_w = 1'b1; end
          4'b01??: begin op = IPSF; lit_op = 1'b1; wr_w = 1'b1; br_op = 1'b1; end
          4'b111?: begin op = IADD; lit_op = 1'b1; wr_w = 1'b1; upd_c = 1'b1; upd_dc = 1'b1; upd_z = 1'b1; end
          4'b110?: begin op = ISUB; lit_op = 1'b1; wr_w = 1'b1; upd_c = 1'b1; upd_dc = 1'b1; upd_z = 1'b1; end
          4'b1001: begin op = IAND; lit_op = 1'b1; wr_w = 1'b1; upd_z = 1'b1; end
          4'b1000: begin op = IIOR; lit_op = 1'b1; wr_w = 1'b1; upd_z = 1'b1; end
          4'b1010: begin op = IXOR; lit_op = 1'b1; wr_w = 1'b1; upd_z = 1'b1; end
          default: ;
        endcase
      end
    endcase
  end

  assign active   = (state != S_IDLE);
  assign exec     = active & ~skip_pend;
  assign in_q4    = (state == S_Q4);
  assign flag_upd = exec & in_q4;
  assign skip_set = (sk_z & bus.z) | (sk_nz & ~bus.z);

  assign bus.ir_rdy = (state == S_IDLE) | in_q4;
  assign accept     = bus.ir_vld & bus.ir_rdy;

  // CALL/GOTO leave rd_f low: they never touch the register file.
  assign bus.cb   = active ? op : IPSW;
  assign bus.lsel = active & lit_op;
  assign bus.br   = exec & br_op;
  assign bus.fre  = exec & (state == S_Q2) & rd_f;
  assign bus.we   = flag_upd & wr_w;
  assign bus.fwe  = flag_upd & wr_f;
  assign bus.b    = ir_q[9:7];
  assign bus.lit  = ir_q[7:0];
  assign bus.fadr = ir_q[6:0];
  assign bus.ci   = c_f;
  assign bus.c_f  = c_f;
  assign bus.dc_f = dc_f;
  assign bus.z_f  = z_f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ir_q      <= 14'h0000;
      skip_pend <= 1'b0;
    end else begin
      case (state)
        S_IDLE:  if (accept) state <= S_Q1;
        S_Q1:    state <= S_Q2;
        S_Q2:    state <= S_Q3;
        S_Q3:    state <= S_Q4;
        S_Q4:    state <= accept ? S_Q1 : S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (accept) ir_q <= bus.ir;
      // A skipped instruction only clears the pending skip; it never sets one.
      if (in_q4) skip_pend <= ~skip_pend & skip_set;
    end
  end

  // Instruction flag updates take priority over a coincident STATUS write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_f  <= 1'b0;
      dc_f <= 1'b0;
      z_f  <= 1'b0;
    end else begin
      if (flag_upd & upd_c)       c_f  <= bus.co;
      else if (bus.stw)           c_f  <= bus.sdi[0];
      if (flag_upd & upd_dc)      dc_f <= bus.dc;
      else if (bus.stw)           dc_f <= bus.sdi[1];
      if (flag_upd & upd_z)       z_f  <= bus.z;
      else if (bus.stw)           z_f  <= bus.sdi[2];
    end
  end
endmodule
